ftq_ptr_ctrl: RTL and testbench
===============================

# ftq_ptr_ctrl

Pointer and sequencing controller for the 8-entry FTQ PC memory. It accepts prediction blocks from the BPU and writes them into the PC memory. It also issues fetch requests to the IFU, retires entries on commit, and rolls pointers back on redirect. It drives the memory's write port and its five next-cycle read addresses: ifuPtr, ifuPtr+1, ifuPtr+2, commPtr and commPtr+1.

## Interface
Parameters:
- ENTRIES, 8, queue depth; must be a power of two.
- PTR_W, 3, index width, log2(ENTRIES).
- VADDR_W, 39, PC width.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- enq_valid / enq_ready  in / out  1 / 1  BPU enqueue handshake; fires when both are high.
- enq_startAddr, enq_nextLineAddr  in  VADDR_W  block PCs.
- enq_fallThruError  in  1  flag stored with the entry.
- ifu_req_valid / ifu_req_ready  out / in  1 / 1  fetch handshake for the entry at ifuPtr.
- ifu_req_idx  out  PTR_W+1  {flag, value} of ifuPtr.
- commit_valid  in  1  retire the entry at commPtr.
- redirect_valid  in  1  flush all entries younger than redirect_ptr.
- redirect_ptr  in  PTR_W+1  {flag, value} of the last surviving entry.
- mem_wen  out  1  PC memory write enable.
- mem_waddr  out  PTR_W  write index.
- mem_wdata_startAddr, mem_wdata_nextLineAddr, mem_wdata_fallThruError  out  VADDR_W / VADDR_W / 1  write data.
- ifuPtr_wvalue, ifuPtrPlus1_wvalue, ifuPtrPlus2_wvalue, commPtr_wvalue, commPtrPlus1_wvalue  out  PTR_W  next-cycle read indices.
- occupancy  out  PTR_W+1  bpuPtr minus commPtr, range 0..ENTRIES.

## Operation
- **Pointers.** Three registered pointers, bpuPtr, ifuPtr and commPtr, each {flag, value}. Incrementing from value ENTRIES-1 wraps value to 0 and toggles flag.
- **Full and empty.** full = values equal and flags differ. empty = bpuPtr == commPtr.
- **Enqueue.**
  - enq_ready = !full && !redirect_valid && !reset.
  - On enq fire, mem_wen=1, mem_waddr=bpuPtr.value and wdata passes through combinationally; bpuPtr then increments.
- **Written-entry tracking.** bpuPtrD1 is bpuPtr delayed one cycle. It guarantees an entry is written at least one edge before its read address is presented.
- **Fetch.** ifu_req_valid = (ifuPtr != bpuPtrD1) && !redirect_valid. On fetch fire, ifuPtr increments.
- **Commit.**
  - commit_valid takes effect only when commPtr != ifuPtr (the entry has been fetched); otherwise it is ignored.
  - When it takes effect, commPtr increments.
- **Redirect.**
  - Precondition: commPtr <= redirect_ptr < bpuPtr in flag-aware order.
  - At the next edge, bpuPtr, bpuPtrD1 and ifuPtr all load redirect_ptr+1; commPtr is unchanged.
  - In the redirect cycle, enqueue is suppressed (enq_ready=0, mem_wen=0) and fetch is blocked.
  - A commit in the same cycle is still honoured.
- **Read addresses.**
  - Each *_wvalue output is the value the corresponding pointer takes after the current edge: ifuPtr_next, ifuPtr_next+1 and ifuPtr_next+2 (mod ENTRIES), commPtr_next, and commPtr_next+1.
  - Because the PC memory is synchronous-read, its data is aligned with the registered pointers in the following cycle.
- **Occupancy.** occupancy = ({1'b?, bpuPtr} − {commPtr}), computed in PTR_W+1 bits with flag-aware subtraction; it reads ENTRIES when full.

## Timing
- Reset values:
  - All pointers and bpuPtrD1 = 0.
  - During reset, enq_ready=0, ifu_req_valid=0, mem_wen=0 and occupancy=0.
  - All *_wvalue outputs present the reset pointer values: 0 for ifuPtr and commPtr, 1 for the Plus1 outputs, 2 for ifuPtrPlus2.
- Reset asserted mid-operation clears all state at the next edge; in-flight handshakes are dropped.
- Latency:
  - An enq fire at cycle t gives ifu_req_valid=1 at cycle t+2 at the earliest.
  - A commit at t lowers occupancy at t+1.
  - A redirect at t makes enq_ready=1 at t+1 if the queue is not full.
- Simultaneous events:
  - enq, fetch and commit in the same cycle are all legal and each updates its own pointer.
  - An enq fire at full is impossible; enq_ready stays 0 even when a commit occurs in the same cycle.

## Configuration
- FTQ_PTR_CTRL_PERF_EN defined: adds outputs perf_full_cycles (32 bits, counts cycles with full=1) and perf_redirects (32 bits, counts redirect_valid cycles). Both saturate at all-ones and are cleared by reset.
- Undefined: neither the counters nor the ports exist.

## Structure
- Package ftq_pkg holds:
  - the ftq_ptr_t struct {flag, value};
  - the ENTRIES and VADDR_W constants;
  - the ptr_inc and ptr_add(n) functions;
  - a flag-aware ptr_lt function.
- One sub-module, ftq_ptr_reg: a single pointer register with inc/load/reset inputs and next-value output. It is instantiated three times.

## Test plan
- **Fill.** Eight back-to-back enq fires from reset with no fetch → enq_ready=0 from cycle 8; occupancy=8; mem_waddr sequence 0..7.
- **Wrap.** Ten enq, fetch and commit cycles in lockstep → bpuPtr={1,2}; commPtr_wvalue follows bpuPtr with lag; no full assertion.
- **Full with commit.** At full, assert enq_valid and commit_valid together (commPtr != ifuPtr) → no enq that cycle; enq_ready=1 next cycle; occupancy=7.
- **Redirect.** bpuPtr=6, ifuPtr=5, redirect_ptr=2 → next cycle bpuPtr=ifuPtr=3 and ifuPtr_wvalue=3; mem_wen=0 in the redirect cycle.
- **Early commit.** commit_valid with commPtr==ifuPtr → commPtr unchanged.
- **Reset mid-stream.** Reset at occupancy 5 → all *_wvalue at reset values; occupancy=0 on the next cycle.

Source files
------------

// File: rtl/ftq_pkg.sv
// ftq_pkg: shared pointer type, queue geometry and pointer arithmetic for the
// FTQ pointer controller.
package ftq_pkg;

  localparam int ENTRIES = 8;
  localparam int PTR_W   = 3;
  localparam int VADDR_W = 39;

  // flag toggles on every wrap, so full and empty can be told apart
  typedef struct packed {
    logic             flag;
    logic [PTR_W-1:0] value;
  } ftq_ptr_t;

  // Adding across the flag bit wraps value and toggles flag, since ENTRIES is a power of two.
  function automatic ftq_ptr_t ptr_add(input ftq_ptr_t p, input logic [PTR_W:0] n);
    logic [PTR_W:0] sum;
    sum = {p.flag, p.value} + n;
    return ftq_ptr_t'(sum);
  endfunction

  function automatic ftq_ptr_t ptr_inc(input ftq_ptr_t p);
    return ptr_add(p, (PTR_W+1)'(1));
  endfunction

  // a is older than b, assuming both lie within one queue span
  function automatic logic ptr_lt(input ftq_ptr_t a, input ftq_ptr_t b);
    if (a.flag == b.flag) return a.value < b.value;
    else                  return a.value > b.value;
  endfunction

endpackage

// File: rtl/ftq_ptr_reg.sv
// ftq_ptr_reg: one {flag, value} queue pointer with reset > load > inc priority.
// ptr_next exposes the post-edge value so synchronous-read memories can be
// addressed one cycle ahead.
module ftq_ptr_reg
  import ftq_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     inc,
  input  logic     load,
  input  ftq_ptr_t load_val,
  output ftq_ptr_t ptr,
  output ftq_ptr_t ptr_next
);

  // next-value selection, reset included so read addresses show 0 during reset
  always_comb begin
    ptr_next = ptr;
    if (reset)     ptr_next = '0;
    else if (load) ptr_next = load_val;
    else if (inc)  ptr_next = ptr_inc(ptr);
  end

  // pointer register
  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/ftq_ptr_ctrl.sv
// ftq_ptr_ctrl: bpu/ifu/commit pointer sequencing for the 8-entry FTQ PC memory.
// Optional feature macro FTQ_PTR_CTRL_PERF_EN adds saturating perf counters
// perf_full_cycles and perf_redirects.
module ftq_ptr_ctrl
  import ftq_pkg::*;
#(
  parameter int ENTRIES = ftq_pkg::ENTRIES,
  parameter int PTR_W   = ftq_pkg::PTR_W,
  parameter int VADDR_W = ftq_pkg::VADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [VADDR_W-1:0] enq_startAddr,
  input  logic [VADDR_W-1:0] enq_nextLineAddr,
  input  logic               enq_fallThruError,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PTR_W:0]     ifu_req_idx,
  input  logic               commit_valid,
  input  logic               redirect_valid,
  input  logic [PTR_W:0]     redirect_ptr,
  output logic               mem_wen,
  output logic [PTR_W-1:0]   mem_waddr,
  output logic [VADDR_W-1:0] mem_wdata_startAddr,
  output logic [VADDR_W-1:0] mem_wdata_nextLineAddr,
  output logic               mem_wdata_fallThruError,
  output logic [PTR_W-1:0]   ifuPtr_wvalue,
  output logic [PTR_W-1:0]   ifuPtrPlus1_wvalue,
  output logic [PTR_W-1:0]   ifuPtrPlus2_wvalue,
  output logic [PTR_W-1:0]   commPtr_wvalue,
  output logic [PTR_W-1:0]   commPtrPlus1_wvalue,
  output logic [PTR_W:0]     occupancy
`ifdef FTQ_PTR_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_full_cycles,
  output logic [31:0]        perf_redirects
`endif
);

  // The pointer struct is sized by the package, so the parameters must agree with it.
  if (ENTRIES != (1 << PTR_W) || PTR_W != ftq_pkg::PTR_W || VADDR_W != ftq_pkg::VADDR_W) begin : g_cfg_check
    $error("ftq_ptr_ctrl: ENTRIES/PTR_W/VADDR_W inconsistent with ftq_pkg");
  end

  ftq_ptr_t bpu_q, bpu_next;
  ftq_ptr_t ifu_q, ifu_next;
  ftq_ptr_t comm_q, comm_next;
  ftq_ptr_t bpu_d1;
  ftq_ptr_t redir_next;

  logic full;
  logic enq_fire;
  logic ifu_fire;
  logic commit_fire;
  logic unused_next_flags;

  assign redir_next = ptr_inc(ftq_ptr_t'(redirect_ptr));

  assign full      = (bpu_q.value == comm_q.value) && (bpu_q.flag != comm_q.flag);
  assign enq_ready = !full && !redirect_valid && !reset;
  assign enq_fire  = enq_valid && enq_ready;

  // bpu_d1 rather than bpu_q gates fetch, so an entry is written before its read address goes out
  assign ifu_req_valid = (ifu_q != bpu_d1) && !redirect_valid && !reset;
  assign ifu_fire      = ifu_req_valid && ifu_req_ready;
  assign ifu_req_idx   = ifu_q;

  // only fetched entries may retire; a commit in a redirect cycle still counts
  assign commit_fire = commit_valid && (comm_q != ifu_q) && !reset;

  assign mem_wen                 = enq_fire;
  assign mem_waddr               = bpu_q.value;
  assign mem_wdata_startAddr     = enq_startAddr;
  assign mem_wdata_nextLineAddr  = enq_nextLineAddr;
  assign mem_wdata_fallThruError = enq_fallThruError;

  ftq_ptr_reg u_bpu_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (enq_fire),
    .load     (redirect_valid),
    .load_val (redir_next),
    .ptr      (bpu_q),
    .ptr_next (bpu_next)
  );

  ftq_ptr_reg u_ifu_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (ifu_fire),
    .load     (redirect_valid),
    .load_val (redir_next),
    .ptr      (ifu_q),
    .ptr_next (ifu_next)
  );

  ftq_ptr_reg u_comm_ptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (commit_fire),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (comm_q),
    .ptr_next (comm_next)
  );

  // bpu_d1 trails bpu_q by one edge, but jumps with it on redirect and reset
  always_ff @(posedge clock) begin
    if (reset || redirect_valid) bpu_d1 <= bpu_next;
    else                         bpu_d1 <= bpu_q;
  end

  // read addresses for the synchronous-read memory, one cycle ahead
  assign ifuPtr_wvalue       = ifu_next.value;
  assign ifuPtrPlus1_wvalue  = ifu_next.value + PTR_W'(1);
  assign ifuPtrPlus2_wvalue  = ifu_next.value + PTR_W'(2);
  assign commPtr_wvalue      = comm_next.value;
  assign commPtrPlus1_wvalue = comm_next.value + PTR_W'(1);

  assign unused_next_flags = ifu_next.flag ^ comm_next.flag;

  // flag-aware difference reads ENTRIES when full
  assign occupancy = reset ? '0 : ({bpu_q.flag, bpu_q.value} - {comm_q.flag, comm_q.value});

`ifdef FTQ_PTR_CTRL_PERF_EN
  // saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_full_cycles <= '0;
      perf_redirects   <= '0;
    end else begin
      if (full && (perf_full_cycles != '1))         perf_full_cycles <= perf_full_cycles + 32'd1;
      if (redirect_valid && (perf_redirects != '1)) perf_redirects   <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ftq_ptr_ctrl.sv
// tb_ftq_ptr_ctrl: scoreboard bench; stimulus predicts outputs from a
// count-based queue model, a negedge monitor compares what the DUT presents.
module tb_ftq_ptr_ctrl;

  localparam int VW = 39;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready;
  logic [VW-1:0] enq_startAddr, enq_nextLineAddr;
  logic          enq_fallThruError;
  logic          ifu_req_valid, ifu_req_ready;
  logic [3:0]    ifu_req_idx;
  logic          commit_valid, redirect_valid;
  logic [3:0]    redirect_ptr;
  logic          mem_wen;
  logic [2:0]    mem_waddr;
  logic [VW-1:0] mem_wdata_startAddr, mem_wdata_nextLineAddr;
  logic          mem_wdata_fallThruError;
  logic [2:0]    ifuPtr_wvalue, ifuPtrPlus1_wvalue, ifuPtrPlus2_wvalue;
  logic [2:0]    commPtr_wvalue, commPtrPlus1_wvalue;
  logic [3:0]    occupancy;
`ifdef FTQ_PTR_CTRL_PERF_EN
  logic [31:0]   perf_full_cycles, perf_redirects;
`endif

  always #5 clock = ~clock;

  ftq_ptr_ctrl dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_startAddr(enq_startAddr), .enq_nextLineAddr(enq_nextLineAddr),
    .enq_fallThruError(enq_fallThruError),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_idx(ifu_req_idx),
    .commit_valid(commit_valid), .redirect_valid(redirect_valid), .redirect_ptr(redirect_ptr),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata_startAddr(mem_wdata_startAddr), .mem_wdata_nextLineAddr(mem_wdata_nextLineAddr),
    .mem_wdata_fallThruError(mem_wdata_fallThruError),
    .ifuPtr_wvalue(ifuPtr_wvalue), .ifuPtrPlus1_wvalue(ifuPtrPlus1_wvalue),
    .ifuPtrPlus2_wvalue(ifuPtrPlus2_wvalue), .commPtr_wvalue(commPtr_wvalue),
    .commPtrPlus1_wvalue(commPtrPlus1_wvalue), .occupancy(occupancy)
`ifdef FTQ_PTR_CTRL_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_redirects(perf_redirects)
`endif
  );

  typedef struct packed {
    logic [3:0] occ;
    logic       er, iv, wen;
    logic [2:0] w0, w1, w2, w3, w4;
  } exp_t;

  typedef struct packed {
    logic [2:0]    addr;
    logic [VW-1:0] sa, nl;
    logic          fte;
  } wr_t;

  exp_t       exp_q[$];
  wr_t        wr_q[$];
  logic [3:0] fetch_q[$];

  int vectors = 0;
  int errors  = 0;
  bit running = 1'b0;

  // model: absolute entry counts; a pointer is its count modulo 2*ENTRIES
  int mb = 0, mi = 0, mc = 0, md = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit rst, input bit ev, input bit ir, input bit cv,
                      input bit rv_in, input int roff);
    exp_t e;
    wr_t  w;
    bit   rv, er, ef, iv, ff, ce;
    int   nb, ni, nc, nd;
    logic [VW-1:0] sa, nl;
    logic fte;
    rv  = rv_in && (roff >= 0) && (roff < mb - mc);
    sa  = VW'({$urandom(), $urandom()});
    nl  = VW'({$urandom(), $urandom()});
    fte = 1'($urandom_range(0, 1));

    reset             = rst;
    enq_valid         = ev;
    enq_startAddr     = sa;
    enq_nextLineAddr  = nl;
    enq_fallThruError = fte;
    ifu_req_ready     = ir;
    commit_valid      = cv;
    redirect_valid    = rv;
    redirect_ptr      = 4'((mc + (rv ? roff : 0)) % 16);

    if (rst) begin
      e = '{occ: 4'd0, er: 1'b0, iv: 1'b0, wen: 1'b0,
            w0: 3'd0, w1: 3'd1, w2: 3'd2, w3: 3'd0, w4: 3'd1};
      mb = 0; mi = 0; mc = 0; md = 0;
    end else begin
      er = (mb - mc != 8) && !rv;
      ef = ev && er;
      iv = (mi != md) && !rv;
      ff = iv && ir;
      ce = cv && (mc != mi);
      if (ef) begin
        w = '{addr: 3'(mb % 8), sa: sa, nl: nl, fte: fte};
        wr_q.push_back(w);
      end
      if (ff) fetch_q.push_back(4'(mi % 16));
      if (rv) begin
        nb = mc + roff + 1; ni = nb; nd = nb;
      end else begin
        nb = mb + (ef ? 1 : 0); ni = mi + (ff ? 1 : 0); nd = mb;
      end
      nc = mc + (ce ? 1 : 0);
      e.occ = 4'(mb - mc);
      e.er  = er;
      e.iv  = iv;
      e.wen = ef;
      e.w0  = 3'(ni % 8);
      e.w1  = 3'((ni + 1) % 8);
      e.w2  = 3'((ni + 2) % 8);
      e.w3  = 3'(nc % 8);
      e.w4  = 3'((nc + 1) % 8);
      mb = nb; mi = ni; mc = nc; md = nd;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // monitor: compares at negedge, away from the active edge
  always @(negedge clock) begin
    if (running) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("occupancy", 64'(occupancy), 64'(e.occ));
        chk("enq_ready", 64'(enq_ready), 64'(e.er));
        chk("ifu_req_valid", 64'(ifu_req_valid), 64'(e.iv));
        chk("mem_wen", 64'(mem_wen), 64'(e.wen));
        chk("ifuPtr_wvalue", 64'(ifuPtr_wvalue), 64'(e.w0));
        chk("ifuPtrPlus1_wvalue", 64'(ifuPtrPlus1_wvalue), 64'(e.w1));
        chk("ifuPtrPlus2_wvalue", 64'(ifuPtrPlus2_wvalue), 64'(e.w2));
        chk("commPtr_wvalue", 64'(commPtr_wvalue), 64'(e.w3));
        chk("commPtrPlus1_wvalue", 64'(commPtrPlus1_wvalue), 64'(e.w4));
      end
      if (mem_wen === 1'b1) begin
        if (wr_q.size() == 0) chk("unexpected_write", 64'(mem_wen), 64'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("mem_waddr", 64'(mem_waddr), 64'(w.addr));
          chk("wdata_startAddr", 64'(mem_wdata_startAddr), 64'(w.sa));
          chk("wdata_nextLineAddr", 64'(mem_wdata_nextLineAddr), 64'(w.nl));
          chk("wdata_fallThruError", 64'(mem_wdata_fallThruError), 64'(w.fte));
        end
      end
      if (ifu_req_valid === 1'b1 && ifu_req_ready === 1'b1) begin
        if (fetch_q.size() == 0) chk("unexpected_fetch", 64'(ifu_req_valid), 64'd0);
        else chk("ifu_req_idx", 64'(ifu_req_idx), 64'(fetch_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_startAddr = '0; enq_nextLineAddr = '0;
    enq_fallThruError = 1'b0; ifu_req_ready = 1'b0; commit_valid = 1'b0;
    redirect_valid = 1'b0; redirect_ptr = '0;
    @(posedge clock);
    #1;
    running = 1'b1;

    // reset state, then fill to full with no fetch (9th enq blocked)
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    // fetch three, then commit and enq together at full
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // redirect: bpuPtr=6, ifuPtr=5, redirect_ptr=2
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 2);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // lockstep wrap; early commits at the start are ignored
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 1, 0, 0);

    // reset mid-stream at occupancy 5
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // randomized traffic with varying commit pressure
    for (int i = 0; i < 1500; i++) begin
      bit rst, ev, ir, cv, rv;
      int roff;
      rst  = ($urandom_range(0, 149) == 0);
      ev   = ($urandom_range(0, 3) != 0);
      ir   = ($urandom_range(0, 2) != 0);
      cv   = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rv   = (mb > mc) && ($urandom_range(0, 24) == 0);
      roff = rv ? int'($urandom_range(0, mb - mc - 1)) : 0;
      step(rst, ev, ir, cv, rv, roff);
    end
    step(0, 0, 0, 0, 0, 0);

    running = 1'b0;
    chk("pending_cycle_checks", 64'(exp_q.size()), 64'd0);
    chk("pending_writes", 64'(wr_q.size()), 64'd0);
    chk("pending_fetches", 64'(fetch_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
